// File: rtl/alu_rs.sv
// ALU reservation station: dispatch, result-broadcast wakeup, single issue per cycle.
// Define ALU_RS_AGE_SELECT_EN to issue the oldest eligible entry instead of the lowest index.
module alu_rs #(
    parameter int XLEN           = 32,
    parameter int ALU_OP_WIDTH   = 4,
    parameter int ROB_SIZE_WIDTH = 5,
    parameter int RS_SIZE        = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      disp_valid,
    input  logic [ALU_OP_WIDTH-1:0]   disp_op,
    input  logic [ROB_SIZE_WIDTH-1:0] disp_id,
    input  logic [XLEN-1:0]           disp_val1,
    input  logic [XLEN-1:0]           disp_val2,
    input  logic                      disp_dep1,
    input  logic                      disp_dep2,
    input  logic [ROB_SIZE_WIDTH-1:0] disp_q1,
    input  logic [ROB_SIZE_WIDTH-1:0] disp_q2,
    output logic                      rs_full,
    input  logic                      alu_ready,
    input  logic [XLEN-1:0]           alu_res,
    input  logic [ROB_SIZE_WIDTH-1:0] alu_id,
    input  logic                      lsb_ready,
    input  logic [XLEN-1:0]           lsb_res,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_id,
    output logic                      rs_ready,
    output logic [ALU_OP_WIDTH-1:0]   rs_op,
    output logic [XLEN-1:0]           rs_val1,
    output logic [XLEN-1:0]           rs_val2,
    output logic [ROB_SIZE_WIDTH-1:0] rs_id
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0]        busy, busy_nxt, elig, dep1, dep2;
    logic [ALU_OP_WIDTH-1:0]   op_q  [RS_SIZE];
    logic [XLEN-1:0]           val1_q[RS_SIZE];
    logic [XLEN-1:0]           val2_q[RS_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] q1_q  [RS_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] q2_q  [RS_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] id_q  [RS_SIZE];

    logic [IDX_W-1:0] free_idx, sel_idx;
    logic             any_elig, do_disp;

    assign rs_full  = &busy;
    assign elig     = busy & ~dep1 & ~dep2;
    assign any_elig = |elig;
    assign do_disp  = disp_valid && !rs_full && !flush;

    // Returns {dep, value} after snooping both broadcast buses; the ALU bus wins a tag tie.
    function automatic logic [XLEN:0] wake(input logic dep,
                                           input logic [ROB_SIZE_WIDTH-1:0] q,
                                           input logic [XLEN-1:0] val);
        if (dep && alu_ready && q == alu_id)
            return {1'b0, alu_res};
        if (dep && lsb_ready && q == lsb_id)
            return {1'b0, lsb_res};
        return {dep, val};
    endfunction

    always_comb begin
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (!busy[i]) free_idx = IDX_W'(i);
    end

`ifdef ALU_RS_AGE_SELECT_EN
    localparam logic [RS_SIZE-1:0] ONE = 1;

    // older[i][j] set means entry i was dispatched before entry j.
    logic [RS_SIZE-1:0] older [RS_SIZE];

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < RS_SIZE; i++)
            if (elig[i] && ((elig & ~older[i] & ~(ONE << i)) == '0))
                sel_idx = IDX_W'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_SIZE; i++) older[i] <= '0;
        end else if (do_disp) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                if (free_idx != IDX_W'(j)) begin
                    older[free_idx][j] <= 1'b0;
                    older[j][free_idx] <= 1'b1;
                end
            end
        end
    end
`else
    // NOTE: assign the default before the loop so sel_idx is driven on every path (no latch).
    always_comb begin
        sel_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (elig[i]) sel_idx = IDX_W'(i);
    end
`endif

    always_comb begin
        busy_nxt = busy;
        if (any_elig) busy_nxt[sel_idx] = 1'b0;
        if (do_disp)  busy_nxt[free_idx] = 1'b1;
    end

    // NOTE: payload storage has no reset; busy alone decides whether an entry's contents are meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (do_disp && free_idx == IDX_W'(i)) begin
                op_q[i]               <= disp_op;
                id_q[i]               <= disp_id;
                q1_q[i]               <= disp_q1;
                q2_q[i]               <= disp_q2;
                {dep1[i], val1_q[i]}  <= wake(disp_dep1, disp_q1, disp_val1);
                {dep2[i], val2_q[i]}  <= wake(disp_dep2, disp_q2, disp_val2);
            end else if (busy[i]) begin
                {dep1[i], val1_q[i]}  <= wake(dep1[i], q1_q[i], val1_q[i]);
                {dep2[i], val2_q[i]}  <= wake(dep2[i], q2_q[i], val2_q[i]);
            end
        end
    end

    // NOTE: state and outputs use non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            rs_ready <= 1'b0;
            rs_op    <= '0;
            rs_val1  <= '0;
            rs_val2  <= '0;
            rs_id    <= '0;
        end else if (flush) begin
            busy     <= '0;
            rs_ready <= 1'b0;
            rs_op    <= '0;
            rs_val1  <= '0;
            rs_val2  <= '0;
            rs_id    <= '0;
        end else begin
            busy     <= busy_nxt;
            rs_ready <= any_elig;
            if (any_elig) begin
                rs_op   <= op_q[sel_idx];
                rs_val1 <= val1_q[sel_idx];
                rs_val2 <= val2_q[sel_idx];
                rs_id   <= id_q[sel_idx];
            end else begin
                rs_op   <= '0;
                rs_val1 <= '0;
                rs_val2 <= '0;
                rs_id   <= '0;
            end
        end
    end

endmodule
